dcf77_decoder: RTL and testbench
================================

DCF77_DECODER -- requirements
Module: dcf77_decoder

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 Parameter CLK_FREQ, default 500, SHALL give the number of clk cycles per second.
REQ-003 Parameter SAMPLE_POINT, default CLK_FREQ*3/20, SHALL give the sampling delay in cycles after clk_en_1hz (150 ms).
REQ-004 Port clk, input, 1 bit, SHALL be the system clock.
REQ-005 Port nReset, input, 1 bit, SHALL be the synchronous active-high reset; value 1 resets the module.
REQ-006 Port dcf_Signal_in, input, 1 bit, SHALL carry the raw DCF77 signal; 0 marks the second pulse: 100 ms low = bit 0, 200 ms low = bit 1.
REQ-007 Port clk_en_1hz, input, 1 bit, SHALL be a one-cycle strobe at the start of each second (falling edge of the DCF signal).
REQ-008 Port minute_start_in, input, 1 bit, SHALL be a one-cycle strobe at second 0, coincident with clk_en_1hz.
REQ-009 Port timeAndDate_out, output, 44 bits, SHALL carry the BCD time and date:
- [43:42] = {DCF bit17 CEST, bit18 CET}
- [41:34] year, [33:29] month, [28:26] weekday, [25:20] day
- [19:14] hour, [13:7] minute, [6:0] second
REQ-010 Port data_valid, output, 1 bit, SHALL be 1 while the last evaluated frame was valid.
REQ-011 Port dcf_value, output, 1 bit, SHALL hold the most recently decoded bit.

Function
REQ-012 Second counter sec_cnt (0..59) SHALL behave as follows:
- minute_start_in sets it to 0, with priority over clk_en_1hz.
- Otherwise clk_en_1hz increments it, wrapping from 59 to 0.
REQ-013 Sample counter SHALL clear on clk_en_1hz, count up, and saturate at SAMPLE_POINT.
REQ-014 When the sample counter reaches SAMPLE_POINT, the block SHALL decode bit = NOT dcf_Signal_in, exactly once per second.
- dcf_value, frame[sec_cnt] and bit count bits_rcvd (saturating at 63) SHALL update in the same cycle.
REQ-015 No sample SHALL occur if clk_en_1hz is absent; a missing second produces no bit.
REQ-016 On minute_start_in, the frame SHALL be evaluated. It is valid only if all of these hold:
- bits_rcvd == 59, frame[0] == 0, frame[20] == 1
- even parity over bits 21..28, 29..35 and 36..58
- minute <= 59, hour <= 23, day 1..31, weekday 1..7, month 1..12, every BCD digit <= 9
REQ-017 Valid frame: in the cycle after minute_start_in, date/time fields [43:7] SHALL be loaded and data_valid = 1.
REQ-018 Invalid frame: data_valid SHALL become 0 in the cycle after minute_start_in, and fields [43:7] SHALL hold their previous values.
REQ-019 After each evaluation, frame and bits_rcvd SHALL clear; a minute_start_in arriving mid-frame SHALL be evaluated (and fail) under the same rule.
REQ-020 timeAndDate_out[6:0] SHALL always equal sec_cnt in BCD, independent of data_valid.
REQ-021 The first frame after reset (no preceding minute_start_in) SHALL never produce data_valid = 1.

Reset
REQ-022 nReset = 1 SHALL clear, in the next cycle, the following to 0: timeAndDate_out, data_valid, dcf_value, sec_cnt, sample counter, frame, bits_rcvd.
REQ-023 Reset asserted mid-frame SHALL discard all partial data; a full 59-bit frame framed by two minute_start_in strobes is then required for data_valid.

Verification
REQ-024 Reset with no other input activity: all outputs = 0.
REQ-025 Pulse decoding at CLK_FREQ = 500: a 50-cycle low pulse yields dcf_value = 0 at cycle 75; a 100-cycle low pulse yields dcf_value = 1.
REQ-026 Valid frame for Thu 2018-07-19 14:37 CEST, correct parities, closed by minute_start_in:
- data_valid = 1
- year 0x18, month 0x07, weekday 4, day 0x19, hour 0x14, minute 0x37
- [43:42] = 2'b10, second 0x00
REQ-027 Same frame with minute parity bit 28 inverted: data_valid = 0, fields [43:7] unchanged.
REQ-028 minute_start_in after only 40 bits: data_valid = 0; the following full valid frame gives data_valid = 1.
REQ-029 Seconds field: after 5 clk_en_1hz strobes following minute_start_in, timeAndDate_out[6:0] = 0x05.

Source files
------------

// File: rtl/dcf77_decoder.sv
// DCF77 minute-frame decoder: samples one bit per second, checks the frame on
// each minute mark and publishes BCD time/date when the frame is plausible.
module dcf77_decoder #(
  parameter int CLK_FREQ     = 500,
  parameter int SAMPLE_POINT = CLK_FREQ * 3 / 20
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic        dcf_Signal_in,
  input  logic        clk_en_1hz,
  input  logic        minute_start_in,
  output logic [43:0] timeAndDate_out,
  output logic        data_valid,
  output logic        dcf_value
);

  localparam int CW = $clog2(SAMPLE_POINT + 1);

  logic [CW-1:0] r_sample_cnt;
  logic          r_armed;
  logic [5:0]    r_sec_cnt;
  logic [58:0]   r_frame;
  logic [5:0]    r_bits_rcvd;
  logic          r_synced;
  logic [36:0]   r_fields;
  logic          r_data_valid;
  logic          r_dcf_value;

  logic w_sample;
  logic w_valid;
  logic w_parity_ok;
  logic w_min_ok, w_hr_ok, w_day_ok, w_wd_ok, w_mon_ok, w_yr_ok;
  logic [2:0] w_sec_tens;
  logic [3:0] w_sec_units;

  // Armed by the second strobe so a missing second can never yield a bit.
  assign w_sample = r_armed && !clk_en_1hz && (r_sample_cnt == CW'(SAMPLE_POINT - 1));

  assign w_parity_ok = ~^r_frame[28:21] && ~^r_frame[35:29] && ~^r_frame[58:36];

  assign w_min_ok = (r_frame[24:21] <= 4'd9) && (r_frame[27:25] <= 3'd5);
  assign w_hr_ok  = (r_frame[32:29] <= 4'd9) &&
                    ((r_frame[34:33] < 2'd2) || ((r_frame[34:33] == 2'd2) && (r_frame[32:29] <= 4'd3)));
  assign w_day_ok = (r_frame[39:36] <= 4'd9) && (r_frame[41:36] != 6'd0) &&
                    ((r_frame[41:40] < 2'd3) || (r_frame[39:36] <= 4'd1));
  assign w_wd_ok  = (r_frame[44:42] != 3'd0);
  assign w_mon_ok = (r_frame[48:45] <= 4'd9) && (r_frame[49:45] != 5'd0) &&
                    (!r_frame[49] || (r_frame[48:45] <= 4'd2));
  assign w_yr_ok  = (r_frame[53:50] <= 4'd9) && (r_frame[57:54] <= 4'd9);

  assign w_valid = r_synced && (r_bits_rcvd == 6'd59) && !r_frame[0] && r_frame[20] &&
                   w_parity_ok && w_min_ok && w_hr_ok && w_day_ok && w_wd_ok &&
                   w_mon_ok && w_yr_ok;

  assign w_sec_tens  = 3'(r_sec_cnt / 6'd10);
  assign w_sec_units = 4'(r_sec_cnt % 6'd10);

  assign timeAndDate_out = {r_fields, w_sec_tens, w_sec_units};
  assign data_valid      = r_data_valid;
  assign dcf_value       = r_dcf_value;

  always_ff @(posedge clk) begin
    if (nReset) begin
      r_sample_cnt <= '0;
      r_armed      <= 1'b0;
      r_sec_cnt    <= '0;
      r_frame      <= '0;
      r_bits_rcvd  <= '0;
      r_synced     <= 1'b0;
      r_fields     <= '0;
      r_data_valid <= 1'b0;
      r_dcf_value  <= 1'b0;
    end else begin
      if (clk_en_1hz) begin
        r_sample_cnt <= '0;
        r_armed      <= 1'b1;
      end else begin
        if (r_sample_cnt != CW'(SAMPLE_POINT))
          r_sample_cnt <= r_sample_cnt + 1'b1;
        if (w_sample)
          r_armed <= 1'b0;
      end

      if (minute_start_in)
        r_sec_cnt <= '0;
      else if (clk_en_1hz)
        r_sec_cnt <= (r_sec_cnt == 6'd59) ? 6'd0 : r_sec_cnt + 1'b1;

      if (w_sample) begin
        r_dcf_value <= ~dcf_Signal_in;
        if (r_sec_cnt <= 6'd58)
          r_frame[r_sec_cnt] <= ~dcf_Signal_in;
        if (r_bits_rcvd != 6'd63)
          r_bits_rcvd <= r_bits_rcvd + 1'b1;
      end

      // Evaluation wins over a same-cycle sample: the new minute starts empty.
      if (minute_start_in) begin
        r_frame      <= '0;
        r_bits_rcvd  <= '0;
        r_synced     <= 1'b1;
        r_data_valid <= w_valid;
        if (w_valid)
          r_fields <= {r_frame[17], r_frame[18], r_frame[57:50], r_frame[49:45],
                       r_frame[44:42], r_frame[41:36], r_frame[34:29], r_frame[27:21]};
      end
    end
  end

endmodule

// File: tb/tb_dcf77_decoder.sv
// Directed bench for dcf77_decoder: 121-cycle seconds, 50/100-cycle low pulses.
module tb_dcf77_decoder;

  logic        clk = 1'b0;
  logic        nReset;
  logic        dcf_Signal_in;
  logic        clk_en_1hz;
  logic        minute_start_in;
  logic [43:0] timeAndDate_out;
  logic        data_valid;
  logic        dcf_value;

  int n_cmp = 0;
  int n_mis = 0;

  logic        pre_a  [59];
  logic        post_a [59];
  logic [6:0]  sec_a  [59];
  logic [58:0] fa, fb;

  // Thu 2018-07-19 14:37 CEST
  localparam logic [43:0] EXP_A = {2'b10, 8'h18, 5'h07, 3'd4, 6'h19, 6'h14, 7'h37, 7'h00};

  dcf77_decoder dut (
    .clk             (clk),
    .nReset          (nReset),
    .dcf_Signal_in   (dcf_Signal_in),
    .clk_en_1hz      (clk_en_1hz),
    .minute_start_in (minute_start_in),
    .timeAndDate_out (timeAndDate_out),
    .data_valid      (data_valid),
    .dcf_value       (dcf_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [43:0] obs, input logic [43:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic ms);
    @(negedge clk);
    clk_en_1hz      = 1'b1;
    minute_start_in = ms;
    dcf_Signal_in   = 1'b0;
    @(negedge clk);
    clk_en_1hz      = 1'b0;
    minute_start_in = 1'b0;
  endtask

  // Rest of a second after the strobe; captures dcf_value around the sample edge.
  task automatic finish_second(input logic b, output logic pre, output logic post);
    int low_len;
    low_len = b ? 100 : 50;
    pre  = 1'b0;
    post = 1'b0;
    for (int k = 1; k < 120; k++) begin
      if (k == low_len) dcf_Signal_in = 1'b1;
      if (k == 75) pre = dcf_value;
      if (k == 76) post = dcf_value;
      @(negedge clk);
    end
  endtask

  task automatic idle_second();
    dcf_Signal_in = 1'b1;
    repeat (120) @(negedge clk);
  endtask

  task automatic send_bits(input logic [58:0] frame, input int n);
    logic p, q;
    for (int s = 0; s < n; s++) begin
      if (s > 0) strobe(1'b0);
      sec_a[s] = timeAndDate_out[6:0];
      finish_second(frame[s], p, q);
      pre_a[s]  = p;
      post_a[s] = q;
    end
  endtask

  initial begin
    int ones [20] = '{17, 20, 21, 22, 23, 25, 26, 28, 31, 33, 36, 39, 40, 44, 45, 46, 47, 53, 54, 58};
    fa = '0;
    foreach (ones[i]) fa[ones[i]] = 1'b1;
    fb = fa;
    fb[28] = ~fb[28];

    nReset = 1'b1; dcf_Signal_in = 1'b1; clk_en_1hz = 1'b0; minute_start_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tad", timeAndDate_out, 44'd0);
    check("reset_dv", 44'(data_valid), 44'd0);
    check("reset_dcf_value", 44'(dcf_value), 44'd0);
    nReset = 1'b0;

    // Frame A opened by the first minute mark; that evaluation must fail.
    strobe(1'b1);
    check("first_eval_dv", 44'(data_valid), 44'd0);
    send_bits(fa, 59);
    check("bit0_post", 44'(post_a[0]), 44'd0);
    check("bit17_pre", 44'(pre_a[17]), 44'd0);
    check("bit17_post", 44'(post_a[17]), 44'd1);
    check("bit18_pre", 44'(pre_a[18]), 44'd1);
    check("bit18_post", 44'(post_a[18]), 44'd0);
    check("bit20_post", 44'(post_a[20]), 44'd1);
    check("sec_after_5", 44'(sec_a[5]), 44'h05);
    check("dv_mid_frame", 44'(data_valid), 44'd0);
    idle_second();
    check("no_strobe_no_sample", 44'(dcf_value), 44'd1);
    check("sec_58", 44'(timeAndDate_out[6:0]), 44'h58);
    strobe(1'b1);
    check("frameA_dv", 44'(data_valid), 44'd1);
    check("frameA_tad", timeAndDate_out, EXP_A);

    // Frame B: minute parity broken.
    send_bits(fb, 59);
    idle_second();
    strobe(1'b1);
    check("badpar_dv", 44'(data_valid), 44'd0);
    check("badpar_hold", 44'(timeAndDate_out[43:7]), 44'(EXP_A[43:7]));
    check("badpar_sec", 44'(timeAndDate_out[6:0]), 44'h00);

    // Short frame, then a full good one.
    send_bits(fa, 40);
    strobe(1'b1);
    check("short_dv", 44'(data_valid), 44'd0);
    check("short_hold", 44'(timeAndDate_out[43:7]), 44'(EXP_A[43:7]));
    send_bits(fa, 59);
    idle_second();
    strobe(1'b1);
    check("after_short_dv", 44'(data_valid), 44'd1);
    check("after_short_tad", timeAndDate_out, EXP_A);

    // Reset mid-frame discards everything, including minute sync.
    send_bits(fa, 20);
    @(negedge clk); nReset = 1'b1;
    @(negedge clk); nReset = 1'b0;
    check("midreset_tad", timeAndDate_out, 44'd0);
    check("midreset_dv", 44'(data_valid), 44'd0);
    check("midreset_dcf_value", 44'(dcf_value), 44'd0);
    strobe(1'b0);
    send_bits(fa, 59);
    idle_second();
    strobe(1'b1);
    check("unsynced_dv", 44'(data_valid), 44'd0);
    send_bits(fa, 59);
    idle_second();
    strobe(1'b1);
    check("resync_dv", 44'(data_valid), 44'd1);
    check("resync_tad", timeAndDate_out, EXP_A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
